// File: rtl/tenyr_serial_pkg.sv
// Shared constants and types for the memory-mapped serial transmitter.
// Register offsets, status bit positions and the transmit state encoding.
package tenyr_serial_pkg;

  localparam logic [31:0] TX_DATA_OFS = 32'd0;
  localparam logic [31:0] TX_STAT_OFS = 32'd1;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/serial_tx_responder_if.sv
// Operand-bus request signals seen by the serial transmitter.
// The bidirectional data lines stay a direct inout port of the responder so
// the tristate driver resolves at the module boundary.
interface serial_tx_responder_if;

  logic        enable;
  logic        rw;
  logic [31:0] addr;

  modport master (output enable, output rw, output addr);
  modport slave  (input enable, input rw, input addr);

endinterface

// File: rtl/serial_tx_fifo.sv
// Byte FIFO feeding the transmitter. Head byte is visible combinationally so
// the transmitter can pop and load its shifter in the same cycle. A push while
// full is accepted only when a pop happens in the same cycle.
module serial_tx_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  output logic [7:0]          pop_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally at the depth; count tracks occupancy.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_responder.sv
// Memory-mapped UART transmitter on the operand bus. Bytes written to BASE are
// queued and sent as 8N1 frames on txd; BASE+1 is the status/control register.
// Optional feature macro: SERIAL_TX_PARITY_EN adds an even-parity bit per frame.
module serial_tx_responder
  import tenyr_serial_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h20,
  parameter int          DEPTH_LOG2 = 3,
  parameter int          CLKDIV     = 16
) (
  input  logic                  clk,
  input  logic                  _reset,
  serial_tx_responder_if.slave  bus,
  inout  wire  [31:0]           data,
  output logic                  txd,
  output logic                  irq
);

  localparam int BAUD_W = $clog2(CLKDIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKDIV - 1);
`ifdef SERIAL_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  tx_state_t           state_reg, state_next;
  logic [BAUD_W-1:0]   baud_reg, baud_next;
  logic [2:0]          bit_idx_reg, bit_idx_next;
  logic [7:0]          shifter_reg, shifter_next;
  logic                txd_reg;
  logic                irq_reg;
  logic                ovf_reg;
  logic                line_bit;
  logic                pop;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_reg, parity_next;
`endif

  logic                wr_data_sel;
  logic                wr_stat_sel;
  logic                rd_stat_sel;
  logic                fifo_full;
  logic                fifo_empty;
  logic [7:0]          fifo_dout;
  logic [DEPTH_LOG2:0] fifo_count;
  logic [31:0]         status;
  logic                unused_data_hi;

  assign wr_data_sel    = bus.enable && bus.rw  && (bus.addr == BASE + TX_DATA_OFS);
  assign wr_stat_sel    = bus.enable && bus.rw  && (bus.addr == BASE + TX_STAT_OFS);
  assign rd_stat_sel    = bus.enable && !bus.rw && (bus.addr == BASE + TX_STAT_OFS);
  assign unused_data_hi = ^data[31:8];

  serial_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    ._reset    (_reset),
    .push      (wr_data_sel),
    .push_data (data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Status word assembled from live FIFO/FSM state.
  always_comb begin
    status              = '0;
    status[15:8]        = 8'(fifo_count);
    status[ST_BUSY]     = (state_reg != IDLE);
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_OVF]      = ovf_reg;
    status[ST_PAR]      = PARITY_EN;
  end

  assign data = rd_stat_sel ? status : 'z;
  assign txd  = txd_reg;
  assign irq  = irq_reg;

  // Transmit sequencing: state, bit timing and the line level for this state.
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shifter_next = shifter_reg;
    pop          = 1'b0;
    line_bit     = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shifter_next = fifo_dout;
          baud_next    = BAUD_LOAD;
          state_next   = START;
`ifdef SERIAL_TX_PARITY_EN
          parity_next  = ^fifo_dout;
`endif
        end
      end
      START: begin
        line_bit = 1'b0;
        if (baud_reg == '0) begin
          baud_next    = BAUD_LOAD;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      DATA: begin
        line_bit = shifter_reg[0];
        if (baud_reg == '0) begin
          baud_next    = BAUD_LOAD;
          shifter_next = {1'b0, shifter_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        line_bit = parity_reg;
        if (baud_reg == '0) begin
          baud_next  = BAUD_LOAD;
          state_next = STOP;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        line_bit = 1'b1;
        if (baud_reg == '0) begin
          state_next = IDLE;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers; txd and irq are registered so the line never glitches.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shifter_reg <= '0;
      txd_reg     <= 1'b1;
      irq_reg     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shifter_reg <= shifter_next;
      txd_reg     <= line_bit;
      irq_reg     <= fifo_empty && (state_reg == IDLE);
`ifdef SERIAL_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  // Sticky overflow: set on a dropped push, cleared by writing bit 3 of status.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ovf_reg <= 1'b0;
    end else if (wr_stat_sel && data[3]) begin
      ovf_reg <= 1'b0;
    end else if (wr_data_sel && fifo_full && !pop) begin
      ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_tx_responder.sv
// Self-checking bench for serial_tx_responder: a frame-level model (byte queue
// plus per-frame bit vector) is compared against txd/irq/status every cycle.
// Honours SERIAL_TX_PARITY_EN the same way as the design.
module tb_serial_tx_responder;
  import tenyr_serial_pkg::*;

  localparam logic [31:0] BASE  = 32'h20;
  localparam int          DEPTH = 8;
  localparam int          CLKDIV = 16;
`ifdef SERIAL_TX_PARITY_EN
  localparam int          NBITS  = 11;
  localparam logic [31:0] PAR_ST = 32'h10;
`else
  localparam int          NBITS  = 10;
  localparam logic [31:0] PAR_ST = 32'h0;
`endif
  localparam int FRAME = NBITS * CLKDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        txd;
  logic        irq;
  logic        drive = 1'b0;
  logic [31:0] wdata = 32'h0;
  wire  [31:0] data;

  assign data = drive ? wdata : 'z;

  serial_tx_responder_if bus ();

  serial_tx_responder #(.BASE(BASE), .DEPTH_LOG2(3), .CLKDIV(CLKDIV)) dut (
    .clk    (clk),
    ._reset (rst_n),
    .bus    (bus),
    .data   (data),
    .txd    (txd),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]       m_q[$];
  bit               m_active = 1'b0;
  int               m_elapsed = 0;
  logic [NBITS-1:0] m_frame = '1;
  bit               m_ovf = 1'b0;
  logic             m_txd = 1'b1;
  logic             m_irq = 1'b1;

  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef SERIAL_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = PAR_ST;
    s[15:8] = 8'(m_q.size());
    s[3]    = m_ovf;
    s[2]    = (m_q.size() == 0);
    s[1]    = (m_q.size() == DEPTH);
    s[0]    = m_active;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_active  = 1'b0;
      m_elapsed = 0;
      m_ovf     = 1'b0;
      m_txd     = 1'b1;
      m_irq     = 1'b1;
    end else begin
      logic old_line;
      logic old_irq;
      old_line = m_active ? m_frame[m_elapsed / CLKDIV] : 1'b1;
      old_irq  = (m_q.size() == 0) && !m_active;
      if (m_active) begin
        m_elapsed++;
        if (m_elapsed == FRAME) m_active = 1'b0;
      end else if (m_q.size() != 0) begin
        m_frame   = frame_of(m_q.pop_front());
        m_active  = 1'b1;
        m_elapsed = 0;
      end
      if (bus.enable && bus.rw && bus.addr == BASE) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else m_ovf = 1'b1;
      end
      if (bus.enable && bus.rw && bus.addr == BASE + 32'd1 && wdata[3]) m_ovf = 1'b0;
      m_txd = old_line;
      m_irq = old_irq;
    end
  end

  // ---------------- single compare process ----------------
  int          checks = 0;
  int          errors = 0;
  bit          lit_en = 1'b0;
  bit          pend_lit = 1'b0;
  logic [31:0] lit_exp = 32'h0;
  string       lit_name = "";
  bit          lit_txd_en = 1'b0;
  logic        lit_txd_exp = 1'b1;
  bit          stall = 1'b0;
  bit          stall_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("reset_txd", 32'(txd), 32'd1);
      chk("reset_irq", 32'(irq), 32'd1);
    end else begin
      chk("txd", 32'(txd), 32'(m_txd));
      chk("irq", 32'(irq), 32'(m_irq));
      if (bus.enable && !bus.rw && bus.addr == BASE + 32'd1) chk("status", data, m_status());
      if (lit_en) chk(lit_name, data, lit_exp);
      if (lit_txd_en) chk("txd_literal", 32'(txd), 32'(lit_txd_exp));
    end
    if (stall && !stall_seen) begin
      stall_seen = 1'b1;
      chk("wait_timeout", 32'd1, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    lit_en     = pend_lit;
    bus.enable = 1'b1;
    bus.rw     = w;
    bus.addr   = a;
    wdata      = d;
    drive      = w;
    #1;
    if (w) $display("WR addr=%h data=%h", a, d);
    else   $display("RD addr=%h data=%h", a, data);
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.rw     = 1'b0;
    drive      = 1'b0;
    lit_en     = 1'b0;
    pend_lit   = 1'b0;
  endtask

  task automatic read_lit(input string name, input logic [31:0] exp);
    pend_lit = 1'b1;
    lit_exp  = exp;
    lit_name = name;
    bus_op(1'b0, BASE + 32'd1, 32'h0);
  endtask

  task automatic lit_frame(input logic [7:0] b, input logic [NBITS-1:0] pat);
    bus_op(1'b1, BASE, {24'h5A5A5A, b});
    for (int c = 0; c < FRAME + 4; c++) begin
      @(negedge clk);
      if (c >= 2 && ((c - 2) % CLKDIV) == CLKDIV / 2 && ((c - 2) / CLKDIV) < NBITS) begin
        lit_txd_en  = 1'b1;
        lit_txd_exp = pat[(c - 2) / CLKDIV];
      end else begin
        lit_txd_en = 1'b0;
      end
    end
    lit_txd_en = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (!m_active && m_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) stall = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.rw     = 1'b0;
    bus.addr   = 32'h0;

    // Reset and idle status.
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    read_lit("reset_status", 32'h4 | PAR_ST);

    // Literal frames.
`ifdef SERIAL_TX_PARITY_EN
    lit_frame(8'hA5, 11'b1_0_10100101_0);
    lit_frame(8'h07, 11'b1_1_00000111_0);
`else
    lit_frame(8'hA5, 10'b1_10100101_0);
    lit_frame(8'h07, 10'b1_00000111_0);
`endif

    // Fill to overflow: one byte in flight, eight queued, tenth dropped.
    for (int i = 0; i < 10; i++) bus_op(1'b1, BASE, 32'h30 + 32'(i));
    read_lit("ovf_status", 32'h0000_080B | PAR_ST);
    bus_op(1'b1, BASE + 32'd1, 32'h8);
    read_lit("ovf_cleared", 32'h0000_0803 | PAR_ST);
    wait_idle(12 * FRAME);

    // Push coincident with the IDLE pop cycle while count is 1.
    bus_op(1'b1, BASE, 32'hC3);
    bus_op(1'b1, BASE, 32'h3C);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        @(posedge clk);
        #1;
        if (!m_active && m_q.size() == 1) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) stall = 1'b1;
    end
    bus_op(1'b1, BASE, 32'h96);
    read_lit("pushpop_count", 32'h0000_0101 | PAR_ST);
    wait_idle(4 * FRAME);

    // Mid-frame reset during data bit 4 (a 0 bit of 0x0F).
    bus_op(1'b1, BASE, 32'h0F);
    bus_op(1'b1, BASE, 32'hF0);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        @(posedge clk);
        #1;
        if (m_active && m_elapsed == 5 * CLKDIV + 8) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) stall = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    read_lit("post_reset_status", 32'h4 | PAR_ST);

    // Randomized traffic.
    for (int n = 0; n < 90; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 50)      bus_op(1'b1, BASE, $urandom);
      else if (r < 58) bus_op(1'b1, BASE + 32'd1, $urandom);
      else if (r < 80) bus_op(1'b0, BASE + 32'd1, 32'h0);
      else if (r < 86) bus_op(1'b0, BASE, 32'h0);
      else if (r < 90) bus_op(1'b1, BASE + 32'd2, $urandom);
      else             repeat ($urandom_range(1, 120)) @(negedge clk);
    end
    wait_idle(12 * FRAME);
    read_lit("final_status", {16'h0, 8'h0, 4'h0, 1'b0, 3'b100} | PAR_ST | (m_ovf ? 32'h8 : 32'h0));

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
